cam_stream_gen: RTL and testbench

- Camera-side transmitter for the OV7670-style parallel interface that the capture path receives.
- Generates vsync, href and 8-bit px_data as RGB565, two bytes per pixel, with synthetic test patterns.
- Used on-board and in benches to drive the capture/frame-buffer path without a physical camera.
- Sits in pclk domain; its outputs connect directly to the capture block's vsync/href/px_data inputs.

---
 rtl/cam_pkg.sv | 57 +++++
 rtl/cam_pattern_rgb565.sv | 43 ++++
 rtl/cam_stream_gen.sv | 196 +++++++++++++++++++
 tb/tb_cam_stream_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera stream generator and the capture path.
package cam_pkg;

  // Default frame geometry shared with the capture block
  localparam int unsigned CAM_H_PX = 160;
  localparam int unsigned CAM_V_LN = 120;

  // RGB565 colour constants
  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // pattern_sel encodings
  typedef enum logic [1:0] {
    PAT_SOLID   = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_RAMP    = 2'd3
  } pattern_e;

  // Generator FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBP    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFP    = 3'd5
  } state_e;

  // One cycle of the parallel camera bus
  typedef struct packed {
    logic       vsync;
    logic       href;
    logic [7:0] data;
  } cam_bus_t;

  // Colour-bar palette, bar 0 on the left
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = RGB_WHITE;
      3'd1:    bar_colour = RGB_YELLOW;
      3'd2:    bar_colour = RGB_CYAN;
      3'd3:    bar_colour = RGB_GREEN;
      3'd4:    bar_colour = RGB_MAGENTA;
      3'd5:    bar_colour = RGB_RED;
      3'd6:    bar_colour = RGB_BLUE;
      default: bar_colour = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_pattern_rgb565.sv
// Test-pattern colour generator: maps pixel coordinates to an RGB565 value.
module cam_pattern_rgb565
  import cam_pkg::*;
#(
  parameter int unsigned H_PX  = CAM_H_PX,
  parameter int unsigned XW    = 8,
  parameter int unsigned YW    = 7,
  parameter logic [15:0] SOLID = RGB_RED
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  pattern_e      i_pattern,
  input  logic [15:0]   i_ramp,
  output logic [15:0]   o_colour_c
);

  // Bar width in pixels; narrow frames collapse to one-pixel bars
  localparam int unsigned BAR_W = (H_PX >= 8) ? (H_PX / 8) : 1;

  logic [31:0] w_bar_q;
  logic [2:0]  w_bar_idx;
  logic        w_cell;

  // Bar index saturates at the rightmost bar when H_PX is not a multiple of 8
  assign w_bar_q   = 32'(i_x) / 32'(BAR_W);
  assign w_bar_idx = (w_bar_q > 32'd7) ? 3'd7 : 3'(w_bar_q);

  // 8x8 checker cell parity
  assign w_cell = ((((32'(i_x) >> 3) ^ (32'(i_y) >> 3)) & 32'd1) != 32'd0);

  // Select the colour for the requested pattern
  always_comb begin
    o_colour_c = SOLID;
    case (i_pattern)
      PAT_SOLID:   o_colour_c = SOLID;
      PAT_BARS:    o_colour_c = bar_colour(w_bar_idx);
      PAT_CHECKER: o_colour_c = w_cell ? RGB_WHITE : RGB_BLACK;
      PAT_RAMP:    o_colour_c = i_ramp;
      default:     o_colour_c = SOLID;
    endcase
  end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style parallel camera transmitter: vsync/href/RGB565 byte stream
// carrying synthetic test patterns, all outputs registered on pclk.
module cam_stream_gen
  import cam_pkg::*;
#(
  parameter int unsigned H_PX    = CAM_H_PX,
  parameter int unsigned V_LN    = CAM_V_LN,
  parameter int unsigned VS_LN   = 3,
  parameter int unsigned VBP_LN  = 2,
  parameter int unsigned VFP_LN  = 2,
  parameter int unsigned H_BLANK = 16,
  parameter logic [15:0] SOLID   = 16'hF800
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       vsync,
  output logic       href,
  output logic [7:0] px_data,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  localparam int unsigned LINE_T = 2 * H_PX + H_BLANK;
  localparam int unsigned ACT_T  = 2 * H_PX;
  localparam int unsigned VS_T   = VS_LN * LINE_T;
  localparam int unsigned VBP_T  = VBP_LN * LINE_T;
  localparam int unsigned VFP_T  = VFP_LN * LINE_T;
  localparam int unsigned MAX_A  = (VS_T > VBP_T) ? VS_T : VBP_T;
  localparam int unsigned MAX_B  = (VFP_T > ACT_T) ? VFP_T : ACT_T;
  localparam int unsigned MAX_T  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int unsigned XW     = (H_PX > 1) ? $clog2(H_PX) : 1;
  localparam int unsigned YW     = (V_LN > 1) ? $clog2(V_LN) : 1;

  localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(VS_T - 1);
  localparam logic [CNT_W-1:0] VBP_LAST  = CNT_W'(VBP_T - 1);
  localparam logic [CNT_W-1:0] VFP_LAST  = CNT_W'(VFP_T - 1);
  localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ACT_T - 1);
  localparam logic [CNT_W-1:0] HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [YW-1:0]    LINE_LAST = YW'(V_LN - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [YW-1:0]    r_line;
  logic [15:0]      r_ramp;
  pattern_e         r_pat;

  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [YW-1:0]    w_line_nxt;
  logic [15:0]      w_ramp_nxt;
  pattern_e         w_pat_nxt;
  logic [XW-1:0]    w_x_nxt;
  logic [15:0]      w_colour;
  cam_bus_t         w_bus_nxt;
  logic             w_done_nxt;
  logic             w_busy_nxt;
  logic [7:0]       w_fcnt_nxt;

  // State and timing-counter registers
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_line  <= '0;
      r_ramp  <= '0;
      r_pat   <= PAT_SOLID;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_line  <= w_line_nxt;
      r_ramp  <= w_ramp_nxt;
      r_pat   <= w_pat_nxt;
    end
  end

  // Next state, cycle counter, line index and ramp counter
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_line_nxt  = r_line;
    w_ramp_nxt  = r_ramp;
    w_pat_nxt   = r_pat;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (enable) begin
          w_state_nxt = ST_VSYNC;
          w_pat_nxt   = pattern_e'(pattern_sel);
        end
      end
      ST_VSYNC: begin
        if (r_cnt == VS_LAST) begin
          w_state_nxt = ST_VBP;
          w_cnt_nxt   = '0;
        end
      end
      ST_VBP: begin
        if (r_cnt == VBP_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
          w_line_nxt  = '0;
          w_ramp_nxt  = '0;
        end
      end
      ST_ACTIVE: begin
        // Ramp advances once per pixel, after its second byte
        if (r_cnt[0]) begin
          w_ramp_nxt = r_ramp + 16'd1;
        end
        if (r_cnt == ACT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_line == LINE_LAST) ? ST_VFP : ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        if (r_cnt == HB_LAST) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
          w_line_nxt  = r_line + YW'(1);
        end
      end
      ST_VFP: begin
        if (r_cnt == VFP_LAST) begin
          w_cnt_nxt = '0;
          if (enable) begin
            w_state_nxt = ST_VSYNC;
            w_pat_nxt   = pattern_e'(pattern_sel);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pixel x of the byte that goes out next cycle
  assign w_x_nxt = XW'(w_cnt_nxt >> 1);

  cam_pattern_rgb565 #(
    .H_PX  (H_PX),
    .XW    (XW),
    .YW    (YW),
    .SOLID (SOLID)
  ) u_pattern (
    .i_x        (w_x_nxt),
    .i_y        (w_line_nxt),
    .i_pattern  (w_pat_nxt),
    .i_ramp     (w_ramp_nxt),
    .o_colour_c (w_colour)
  );

  // Next-cycle bus values and frame bookkeeping, derived from the next state
  always_comb begin
    w_bus_nxt       = '0;
    w_done_nxt      = 1'b0;
    w_fcnt_nxt      = frame_cnt;
    w_busy_nxt      = (w_state_nxt != ST_IDLE);
    w_bus_nxt.vsync = (w_state_nxt == ST_VSYNC);
    if (w_state_nxt == ST_ACTIVE) begin
      w_bus_nxt.href = 1'b1;
      w_bus_nxt.data = w_cnt_nxt[0] ? w_colour[7:0] : w_colour[15:8];
    end
    if ((w_state_nxt == ST_VFP) && (w_cnt_nxt == VFP_LAST)) begin
      w_done_nxt = 1'b1;
      w_fcnt_nxt = frame_cnt + 8'd1;
    end
  end

  // Output registers
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vsync      <= 1'b0;
      href       <= 1'b0;
      px_data    <= 8'd0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      vsync      <= w_bus_nxt.vsync;
      href       <= w_bus_nxt.href;
      px_data    <= w_bus_nxt.data;
      frame_done <= w_done_nxt;
      busy       <= w_busy_nxt;
      frame_cnt  <= w_fcnt_nxt;
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen: captures whole frames from a 16x9 configuration
// and compares timing and pixel contents against hand-derived values.
module tb_cam_stream_gen;

  localparam int H   = 16;
  localparam int V   = 9;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int HB  = 2;
  localparam int LT         = 2 * H + HB;                                     // 34
  localparam int FIRST_HREF = (VS + VBP) * LT;                                // 68
  localparam int FRAME_T    = (VS + VBP + VFP) * LT + V * 2 * H + (V - 1) * HB; // 406
  localparam int CYC_LIMIT  = 2 * FRAME_T;

  logic       pclk;
  logic       rst;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       vsync;
  logic       href;
  logic [7:0] px_data;
  logic       frame_done;
  logic       busy;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cap [V][2*H];
  int n_vs, vs_first, n_href, burst_err, nz_outside, fd_idx, busy_low, model_err;

  typedef struct {
    logic [1:0]  pat;
    int          x;
    int          y;
    logic [15:0] expv;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  cam_stream_gen #(
    .H_PX    (H),
    .V_LN    (V),
    .VS_LN   (VS),
    .VBP_LN  (VBP),
    .VFP_LN  (VFP),
    .H_BLANK (HB),
    .SOLID   (16'hF800)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .frame_done  (frame_done),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Reference colour, written from the pattern definitions
  function automatic logic [15:0] model_rgb(input int pat, input int x, input int y);
    int bar;
    case (pat)
      0: return 16'hF800;
      1: begin
        bar = x / (H / 8);
        if (bar > 7) bar = 7;
        case (bar)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2: return (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
      default: return 16'((y * H + x) % 65536);
    endcase
  endfunction

  // Record one frame starting at the edge after the caller raised enable
  // (or straight after the previous frame_done), then check it.
  task automatic capture(input int drop_at, input int sel_at, input logic [1:0] sel_val,
                         input int exp_pat, input int exp_cnt);
    int  line_idx;
    int  byte_idx;
    logic prev_href;
    for (int yy = 0; yy < V; yy++)
      for (int bb = 0; bb < 2 * H; bb++) cap[yy][bb] = 8'h5A;
    n_vs = 0; vs_first = -1; n_href = 0; burst_err = 0; nz_outside = 0;
    fd_idx = -1; busy_low = 0; model_err = 0;
    line_idx = -1; byte_idx = 0; prev_href = 1'b0;
    for (int n = 0; n < CYC_LIMIT && fd_idx < 0; n++) begin
      @(negedge pclk);
      if (vsync) begin
        n_vs++;
        if (vs_first < 0) vs_first = n;
      end
      if (href) begin
        if (!prev_href) begin
          line_idx++;
          byte_idx = 0;
          if (n != FIRST_HREF + line_idx * LT) burst_err++;
        end
        if (line_idx < V && byte_idx < 2 * H) cap[line_idx][byte_idx] = px_data;
        else burst_err++;
        byte_idx++;
        n_href++;
      end else begin
        if (prev_href && byte_idx != 2 * H) burst_err++;
        if (px_data != 8'd0) nz_outside++;
      end
      if (!busy) busy_low++;
      if (frame_done) fd_idx = n;
      prev_href = href;
      if (n == drop_at) enable = 1'b0;
      if (n == sel_at) pattern_sel = sel_val;
    end
    for (int yy = 0; yy < V; yy++)
      for (int xx = 0; xx < H; xx++)
        if ({cap[yy][2*xx], cap[yy][2*xx+1]} != model_rgb(exp_pat, xx, yy)) model_err++;
    chk($sformatf("f%0d_vsync_first", exp_cnt), vs_first, 0);
    chk($sformatf("f%0d_vsync_len", exp_cnt), n_vs, VS * LT);
    chk($sformatf("f%0d_href_bytes", exp_cnt), n_href, V * 2 * H);
    chk($sformatf("f%0d_burst_timing", exp_cnt), burst_err, 0);
    chk($sformatf("f%0d_data_zero_outside", exp_cnt), nz_outside, 0);
    chk($sformatf("f%0d_busy_in_frame", exp_cnt), busy_low, 0);
    chk($sformatf("f%0d_frame_done_cycle", exp_cnt), fd_idx, FRAME_T - 1);
    chk($sformatf("f%0d_frame_cnt", exp_cnt), int'(frame_cnt), exp_cnt);
    chk($sformatf("f%0d_pixel_errors_pat%0d", exp_cnt, exp_pat), model_err, 0);
  endtask

  // Compare the hand-computed table entries for one pattern
  task automatic check_table(input int pat);
    for (int i = 0; i < NVEC; i++) begin
      if (int'(vecs[i].pat) == pat) begin
        logic [15:0] got;
        got = {cap[vecs[i].y][2*vecs[i].x], cap[vecs[i].y][2*vecs[i].x+1]};
        chk($sformatf("pat%0d_px_x%0d_y%0d", pat, vecs[i].x, vecs[i].y),
            int'(got), int'(vecs[i].expv));
      end
    end
  endtask

  initial begin
    int waited;
    // pattern, x, y, expected RGB565
    vecs[0]  = '{2'd0, 0, 0, 16'hF800};
    vecs[1]  = '{2'd0, 15, 8, 16'hF800};
    vecs[2]  = '{2'd1, 0, 4, 16'hFFFF};
    vecs[3]  = '{2'd1, 2, 4, 16'hFFE0};
    vecs[4]  = '{2'd1, 5, 0, 16'h07FF};
    vecs[5]  = '{2'd1, 7, 8, 16'h07E0};
    vecs[6]  = '{2'd1, 8, 2, 16'hF81F};
    vecs[7]  = '{2'd1, 11, 3, 16'hF800};
    vecs[8]  = '{2'd1, 12, 6, 16'h001F};
    vecs[9]  = '{2'd1, 15, 8, 16'h0000};
    vecs[10] = '{2'd2, 0, 0, 16'h0000};
    vecs[11] = '{2'd2, 8, 0, 16'hFFFF};
    vecs[12] = '{2'd2, 0, 8, 16'hFFFF};
    vecs[13] = '{2'd2, 8, 8, 16'h0000};
    vecs[14] = '{2'd2, 7, 7, 16'h0000};
    vecs[15] = '{2'd2, 15, 3, 16'hFFFF};
    vecs[16] = '{2'd3, 0, 0, 16'h0000};
    vecs[17] = '{2'd3, 3, 0, 16'h0003};
    vecs[18] = '{2'd3, 0, 1, 16'h0010};
    vecs[19] = '{2'd3, 5, 2, 16'h0025};
    vecs[20] = '{2'd3, 15, 8, 16'h008F};

    rst = 1'b0;
    enable = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge pclk);
    chk("rst_vsync", int'(vsync), 0);
    chk("rst_href", int'(href), 0);
    chk("rst_px_data", int'(px_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);

    rst = 1'b1;
    repeat (4) @(negedge pclk);
    chk("idle_busy_no_enable", int'(busy), 0);
    chk("idle_vsync_no_enable", int'(vsync), 0);

    // Solid frame, enable dropped during line 1, pattern_sel changed mid-frame
    pattern_sel = 2'd0;
    enable = 1'b1;
    capture(110, 120, 2'd3, 0, 1);
    check_table(0);
    @(negedge pclk);
    chk("done_pulse_one_cycle", int'(frame_done), 0);
    chk("idle_after_drop_busy", int'(busy), 0);
    chk("idle_after_drop_vsync", int'(vsync), 0);
    repeat (5) @(negedge pclk);
    chk("frame_cnt_hold_idle", int'(frame_cnt), 1);
    chk("stay_idle_busy", int'(busy), 0);

    // Colour bars with enable held; pattern_sel moves to checker mid-frame
    pattern_sel = 2'd1;
    enable = 1'b1;
    capture(-1, 150, 2'd2, 1, 2);
    check_table(1);

    // Back-to-back frame picks up the checkerboard at the frame boundary
    capture(200, -1, 2'd0, 2, 3);
    check_table(2);
    @(negedge pclk);
    chk("idle_after_b2b_busy", int'(busy), 0);

    // Ramp frame with enable only held for the first cycle
    pattern_sel = 2'd3;
    enable = 1'b1;
    capture(0, -1, 2'd0, 3, 4);
    check_table(3);

    // Asynchronous reset in the middle of an active line
    pattern_sel = 2'd0;
    enable = 1'b1;
    waited = 0;
    while (!href && waited < CYC_LIMIT) begin
      @(negedge pclk);
      waited++;
    end
    chk("reach_active_before_reset", int'(href), 1);
    repeat (5) @(negedge pclk);
    @(posedge pclk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_href", int'(href), 0);
    chk("midrst_px_data", int'(px_data), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_frame_cnt", int'(frame_cnt), 0);
    @(negedge pclk);
    rst = 1'b1;
    capture(5, -1, 2'd0, 0, 1);
    @(negedge pclk);
    chk("idle_after_rst_frame_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
